// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: a 4-byte little-endian word count,
// then that many little-endian words, each written as one memory write.
module imem_loader #(
  parameter int          NUM_WORDS = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  words_loaded,
  output logic [2:0]  fsm_state
);

  // Handshake: a byte moves on a rising edge only when byte_valid && byte_ready.
  // byte_ready depends only on the current state, so a producer may hold
  // byte_valid high indefinitely; a byte offered while byte_ready=0 is untouched.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] MAX_COUNT = 32'(NUM_WORDS);
  localparam logic [31:0] MAX_ADDR  = BASE_ADDR + 32'(4 * (NUM_WORDS - 1));

  state_t      state;
  state_t      next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] n_words;
  logic [31:0] next_word;
  logic [31:0] word_addr;
  logic        xfer;
  logic        start_ok;
  logic        last_byte;
  logic        last_word;

  // Shifting from the top leaves the first byte in [7:0] after four bytes.
  assign next_word = {byte_data, asm_word[31:8]};
  assign word_addr = BASE_ADDR + {24'd0, words_loaded, 2'b00};
  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
  assign last_byte = xfer && (byte_cnt == 2'd3);
  assign last_word = (32'(words_loaded) + 32'd1) == n_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) next_state = HDR;
      end
      HDR: begin
        if (last_byte) begin
          if (next_word == 32'd0 || next_word > MAX_COUNT) next_state = ERR;
          else                                            next_state = DATA;
        end
      end
      DATA: begin
        if (last_byte) next_state = WRITE;
      end
      WRITE: begin
        next_state = last_word ? DONE : DATA;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    fsm_state  = state;
    case (state)
      HDR:     begin byte_ready = 1'b1; busy = 1'b1; end
      DATA:    begin byte_ready = 1'b1; busy = 1'b1; end
      WRITE:   begin we = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // waddr/wdata are captured with the final byte so they are stable during
  // WRITE and keep their values afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt     <= 2'd0;
      asm_word     <= 32'd0;
      n_words      <= 32'd0;
      words_loaded <= 6'd0;
      waddr        <= 32'd0;
      wdata        <= 32'd0;
    end else begin
      if (start_ok) begin
        byte_cnt     <= 2'd0;
        words_loaded <= 6'd0;
      end
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_word <= next_word;
        if (byte_cnt == 2'd3) begin
          if (state == HDR) begin
            n_words <= next_word;
          end else begin
            waddr <= word_addr;
            wdata <= next_word;
          end
        end
      end
      if (state == WRITE) words_loaded <= words_loaded + 6'd1;
    end
  end

  a_addr_bound: assert property (@(posedge clk) disable iff (reset) we |-> (waddr <= MAX_ADDR));
  a_we_single:  assert property (@(posedge clk) disable iff (reset) we |=> !we);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed streams, a write scoreboard
// fed from an expected queue, and a one-line summary.
module tb_imem_loader;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic        clk;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  words_loaded;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;
  int we_mark;
  logic prev_we = 1'b0;
  logic [63:0] exp_q[$];

  imem_loader #(.NUM_WORDS(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write pulse must match the head of exp_q
  always @(negedge clk) begin
    if (we) begin
      we_count++;
      check("we_single_cycle", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) check("unexpected_we", 64'd1, 64'd0);
      else                   check("write", {waddr, wdata}, exp_q.pop_front());
    end
    if (busy) check("ready_vs_we", 64'(byte_ready), 64'(!we));
    prev_we = we;
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    int t;
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("byte_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'(S_IDLE));
    check("rst_outs", {32'(busy), 32'(done)}, 64'd0);
    check("rst_ready_we", {32'(byte_ready), 32'(we)}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // back-to-back two-word load
    pulse_start();
    check("t1_hdr", 64'(fsm_state), 64'(S_HDR));
    exp_q.push_back({32'h0, 32'h00500113});
    exp_q.push_back({32'h4, 32'h00C00193});
    we_mark = we_count;
    send_word(32'h2, 0);
    send_word(32'h00500113, 0);
    check("t1_we_lat0", 64'(we), 64'd1);
    send_word(32'h00C00193, 0);
    check("t1_we_lat1", 64'(we), 64'd1);
    idle(1);
    check("t1_done", {32'(done), 32'(err)}, {32'd1, 32'd0});
    check("t1_words", 64'(words_loaded), 64'd2);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_we_count", 64'(we_count - we_mark), 64'd2);

    // same stream with 3 idle cycles between bytes
    pulse_start();
    exp_q.push_back({32'h0, 32'h00500113});
    exp_q.push_back({32'h4, 32'h00C00193});
    we_mark = we_count;
    send_word(32'h2, 3);
    send_word(32'h00500113, 3);
    send_word(32'h00C00193, 3);
    check("t2_done", 64'(done), 64'd1);
    check("t2_words", 64'(words_loaded), 64'd2);
    check("t2_we_count", 64'(we_count - we_mark), 64'd2);
    check("t2_waddr_hold", {waddr, wdata}, {32'h4, 32'h00C00193});

    // bad headers: N=0 then N=33
    pulse_start();
    check("t3_done_cleared", {32'(done), 32'(words_loaded)}, 64'd0);
    we_mark = we_count;
    send_word(32'h0, 0);
    check("t3a_err", {32'(err), 32'(done)}, {32'd1, 32'd0});
    check("t3a_state", 64'(fsm_state), 64'(S_ERR));
    byte_valid = 1'b1; byte_data = 8'h13;
    repeat (3) begin
      check("t3a_ready", 64'(byte_ready), 64'd0);
      @(negedge clk);
    end
    pulse_start();
    check("t3b_err_cleared", 64'(err), 64'd0);
    send_word(32'h21, 0);
    check("t3b_err", {32'(err), 32'(done)}, {32'd1, 32'd0});
    byte_valid = 1'b1;
    repeat (3) begin
      check("t3b_ready", 64'(byte_ready), 64'd0);
      @(negedge clk);
    end
    check("t3_no_we", 64'(we_count - we_mark), 64'd0);

    // reset mid-load, overriding start and byte_valid
    pulse_start();
    we_mark = we_count;
    send_word(32'h1, 0);
    send_byte(8'h13);
    send_byte(8'h01);
    reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h50;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("t4_state", 64'(fsm_state), 64'(S_IDLE));
    check("t4_addr_data", {waddr, wdata}, 64'd0);
    check("t4_flags", {32'(byte_ready), 8'(we), 8'(busy), 8'(done), 8'(err)}, 64'd0);
    check("t4_words", 64'(words_loaded), 64'd0);
    repeat (3) begin
      check("t4_need_start", 64'(byte_ready), 64'd0);
      @(negedge clk);
    end
    check("t4_no_we", 64'(we_count - we_mark), 64'd0);
    pulse_start();
    exp_q.push_back({32'h0, 32'h00500113});
    send_word(32'h1, 0);
    send_word(32'h00500113, 0);
    idle(1);
    check("t4_reload", {32'(done), 32'(words_loaded)}, {32'd1, 32'd1});
    check("t4_reload_we", 64'(we_count - we_mark), 64'd1);

    // start during DATA is ignored
    pulse_start();
    exp_q.push_back({32'h0, 32'h00500113});
    exp_q.push_back({32'h4, 32'h00C00193});
    send_word(32'h2, 0);
    send_byte(8'h13);
    start = 1'b1;
    send_byte(8'h01);
    start = 1'b0;
    send_byte(8'h50);
    send_byte(8'h00);
    send_word(32'h00C00193, 0);
    idle(1);
    check("t5_done", 64'(done), 64'd1);
    check("t5_words", 64'(words_loaded), 64'd2);

    // start in DONE, then full 32-word load
    pulse_start();
    check("t5_restart_state", 64'(fsm_state), 64'(S_HDR));
    check("t5_restart_flags", {32'(done), 32'(words_loaded)}, 64'd0);
    check("t5_restart_busy", 64'(busy), 64'd1);
    we_mark = we_count;
    send_word(32'd32, 0);
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back({32'(4 * k), 32'(4 * k)});
      send_word(32'(4 * k), 0);
    end
    idle(1);
    check("t6_done", 64'(done), 64'd1);
    check("t6_words", 64'(words_loaded), 64'd32);
    check("t6_last_write", {waddr, wdata}, {32'd124, 32'd124});
    check("t6_we_count", 64'(we_count - we_mark), 64'd32);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
